// File: rtl/matrix_pkg.sv
// matrix_pkg
//   Shared definitions for the matrix result readout path.
//   - reader_state_t    : readout FSM states (idle, issuing reads, draining)
//   - RESULT_FIFO_DEPTH : entries in the show-ahead buffer; also the number
//                         of Z RAM reads allowed to be outstanding
//   Optional feature macro used by the readout files:
//   MATRIX_READER_ROW_LAST_EN.
package matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

  localparam int RESULT_FIFO_DEPTH = 2;

endpackage

// File: rtl/result_fifo.sv
// result_fifo
//   Small show-ahead FIFO holding Z words plus their tag bits. The head
//   entry is visible on head_data whenever count is non-zero, so it can be
//   driven straight onto a valid/ready stream.
//   Parameters:
//     WIDTH      - bits per entry (data plus tags)
//   Ports:
//     clk        - clock, rising edge
//     rst        - asynchronous active-high reset (empties FIFO, zeroes entries)
//     push       - write push_data at the tail
//     push_data  - entry to write
//     pop        - drop the head entry
//     head_data  - current head entry (zero after reset)
//     count      - number of valid entries
module result_fifo
  import matrix_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   push,
  input  logic [WIDTH-1:0]                       push_data,
  input  logic                                   pop,
  output logic [WIDTH-1:0]                       head_data,
  output logic [$clog2(RESULT_FIFO_DEPTH+1)-1:0] count
);

  localparam int DEPTH = RESULT_FIFO_DEPTH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] entry_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  logic pop_eff;
  logic push_eff;

  // Guard against misuse: never pop empty, never overwrite a live entry.
  assign pop_eff  = pop && (count_reg != '0);
  assign push_eff = push && ((count_reg != CNT_W'(DEPTH)) || pop_eff);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        entry_reg[gi] <= '0;
      end else if (push_eff && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg[gi] <= push_data;
      end
    end
  end

  // Pointers advance modulo DEPTH (a power of two here, so they wrap freely).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_eff) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head_data = entry_reg[rd_ptr_reg];
  assign count     = count_reg;

endmodule

// File: rtl/matrix_result_reader.sv
// matrix_result_reader
//   Streams a finished result matrix Z out of the Z RAM in row-major order.
//   Read addresses are issued only while the buffer plus the read in flight
//   leaves room, so backpressure never loses a word and at most two reads
//   are ever outstanding.
//   Optional feature: define MATRIX_READER_ROW_LAST_EN to add out_row_last,
//   which marks the final element of every row.
//   Parameters:
//     ADDR_WIDTH   - width of z_addr, z_rows, z_cols and internal counters
//     DATA_WIDTH   - width of Z RAM words and stream data
//   Ports:
//     clk, rst     - clock; asynchronous active-high reset
//     start        - begin readout (only honoured when idle)
//     z_rows/z_cols- Z dimensions, captured at an accepted start
//     z_data       - Z RAM read data, one cycle after z_addr
//     z_addr       - Z RAM read address (registered)
//     out_data/out_valid/out_ready/out_last - output stream
//     out_row_last - (optional) row-end marker
//     busy         - readout in progress
//     done         - one-cycle completion pulse
module matrix_result_reader
  import matrix_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] z_rows,
  input  logic [ADDR_WIDTH-1:0] z_cols,
  input  logic [DATA_WIDTH-1:0] z_data,
  output logic [ADDR_WIDTH-1:0] z_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
`ifdef MATRIX_READER_ROW_LAST_EN
  output logic                  out_row_last,
`endif
  output logic                  busy,
  output logic                  done
);

`ifdef MATRIX_READER_ROW_LAST_EN
  localparam int TAG_W = 2;
`else
  localparam int TAG_W = 1;
`endif
  localparam int FIFO_W = DATA_WIDTH + TAG_W;
  localparam int CNT_W  = $clog2(RESULT_FIFO_DEPTH + 1);

  reader_state_t state_reg, state_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;

  logic [ADDR_WIDTH-1:0] rows_reg;
  logic [ADDR_WIDTH-1:0] cols_reg;
  logic [ADDR_WIDTH-1:0] row_reg;
  logic [ADDR_WIDTH-1:0] col_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;

  // A read issued last cycle: its data is on z_data now and is pushed at
  // the end of this cycle, together with the tags computed at issue time.
  logic inflight_reg;
  logic inflight_last_reg;
`ifdef MATRIX_READER_ROW_LAST_EN
  logic inflight_row_last_reg;
`endif

  logic [FIFO_W-1:0] fifo_push_data;
  logic [FIFO_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;

  logic       pop;
  logic       issue;
  logic [2:0] occupancy;
  logic       col_at_end;
  logic       row_at_end;
  logic       elem_last;
  logic       start_ok;
  logic       zero_dim;

  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid && out_ready;

  // Entries committed after this cycle: buffered + arriving - leaving.
  // pop implies fifo_count >= 1, so this never underflows.
  assign occupancy = 3'(fifo_count) + {2'b00, inflight_reg} - {2'b00, pop};
  assign issue     = (state_reg == ST_READ) && (occupancy < 3'(RESULT_FIFO_DEPTH));

  assign col_at_end = (col_reg == cols_reg - ADDR_WIDTH'(1));
  assign row_at_end = (row_reg == rows_reg - ADDR_WIDTH'(1));
  assign elem_last  = col_at_end && row_at_end;

  assign start_ok = (state_reg == ST_IDLE) && start;
  assign zero_dim = (z_rows == '0) || (z_cols == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state plus registered-output targets
  always_comb begin
    state_next = state_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (zero_dim) begin
            done_next = 1'b1;
          end else begin
            state_next = ST_READ;
            busy_next  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (issue && elem_last) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Nothing buffered or arriving once this cycle's pop is taken.
        if (occupancy == 3'd0) begin
          state_next = ST_IDLE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      busy_reg <= busy_next;
      done_reg <= done_next;
    end
  end

  // Address / row / column walk. Termination is by row and column compare,
  // so no z_rows*z_cols product is ever formed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_reg          <= '0;
      cols_reg          <= '0;
      row_reg           <= '0;
      col_reg           <= '0;
      addr_reg          <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
`ifdef MATRIX_READER_ROW_LAST_EN
      inflight_row_last_reg <= 1'b0;
`endif
    end else begin
      inflight_reg      <= issue;
      inflight_last_reg <= issue && elem_last;
`ifdef MATRIX_READER_ROW_LAST_EN
      inflight_row_last_reg <= issue && col_at_end;
`endif
      if (start_ok) begin
        rows_reg <= z_rows;
        cols_reg <= z_cols;
        row_reg  <= '0;
        col_reg  <= '0;
        addr_reg <= '0;
      end else if (issue) begin
        addr_reg <= addr_reg + ADDR_WIDTH'(1);
        if (col_at_end) begin
          col_reg <= '0;
          row_reg <= row_reg + ADDR_WIDTH'(1);
        end else begin
          col_reg <= col_reg + ADDR_WIDTH'(1);
        end
      end
    end
  end

`ifdef MATRIX_READER_ROW_LAST_EN
  assign fifo_push_data = {inflight_row_last_reg, inflight_last_reg, z_data};
  assign out_row_last   = fifo_head[DATA_WIDTH+1];
`else
  assign fifo_push_data = {inflight_last_reg, z_data};
`endif

  result_fifo #(
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_reg),
    .push_data (fifo_push_data),
    .pop       (pop),
    .head_data (fifo_head),
    .count     (fifo_count)
  );

  assign out_data = fifo_head[DATA_WIDTH-1:0];
  assign out_last = fifo_head[DATA_WIDTH];
  assign z_addr   = addr_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_matrix_result_reader.sv
// tb_matrix_result_reader
//   Randomised bench for matrix_result_reader. A behavioural Z RAM answers
//   reads one cycle late; the reference is the row-major list of matrix
//   elements with their last / row-last marks, consumed as words transfer.
module tb_matrix_result_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] z_rows;
  logic [31:0] z_cols;
  logic [31:0] z_data;
  logic [31:0] z_addr;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef MATRIX_READER_ROW_LAST_EN
  logic        out_row_last;
`endif
  logic        busy;
  logic        done;

  matrix_result_reader #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .z_rows       (z_rows),
    .z_cols       (z_cols),
    .z_data       (z_data),
    .z_addr       (z_addr),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
`ifdef MATRIX_READER_ROW_LAST_EN
    .out_row_last (out_row_last),
`endif
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Behavioural Z RAM with one cycle of read latency
  logic [31:0] z_mem [64];
  always @(posedge clk) z_data <= z_mem[z_addr[5:0]];

  typedef struct {
    logic [31:0] d;
    logic        last;
    logic        rl;
  } exp_t;

  int checks = 0;
  int passed = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_z_addr"}, 64'(z_addr), 64'd0);
    check_val({tag, "_out_data"}, 64'(out_data), 64'd0);
    check_val({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check_val({tag, "_out_last"}, 64'(out_last), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
    check_val({tag, "_done"}, 64'(done), 64'd0);
`ifdef MATRIX_READER_ROW_LAST_EN
    check_val({tag, "_out_row_last"}, 64'(out_row_last), 64'd0);
`endif
  endtask

  // fill: 0 random, 1 values 1..N, 2 single 0xDEADBEEF
  // mode: 0 ready high, 1 ready pattern 1,0,0, 2 random ready
  task automatic run(input int rows, input int cols, input int mode, input int fill,
                     input int abort_after, input int inject);
    exp_t        q[$];
    exp_t        e;
    int          n;
    int          accepted;
    int          first_t;
    bit          finished;
    bit          ready;
    bit          prev_valid;
    bit          prev_ready;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [31:0] ahead;

    n = rows * cols;
    for (int i = 0; i < n; i++) begin
      if (fill == 1)      z_mem[i] = 32'(i + 1);
      else if (fill == 2) z_mem[i] = 32'hDEADBEEF;
      else                z_mem[i] = $urandom;
      e.d    = z_mem[i];
      e.last = (i == n - 1);
      e.rl   = ((i % cols) == cols - 1);
      q.push_back(e);
    end

    @(negedge clk);
    start     = 1'b1;
    z_rows    = 32'(rows);
    z_cols    = 32'(cols);
    out_ready = 1'b1;
    accepted  = 0;
    first_t   = -1;
    finished  = 1'b0;
    prev_valid = 1'b0;
    prev_ready = 1'b1;
    prev_data  = '0;
    prev_last  = 1'b0;

    for (int t = 1; t < 400 && !finished; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (inject != 0 && t == 2) begin
        start  = 1'b1;
        z_rows = 32'd5;
        z_cols = 32'd5;
      end
      if (mode == 0)      ready = 1'b1;
      else if (mode == 1) ready = ((t - 1) % 3 == 0);
      else                ready = 1'($urandom_range(0, 1));
      out_ready = ready;

      if (n == 0) begin
        check_val("zero_done", 64'(done), 64'(t == 1));
        check_val("zero_busy", 64'(busy), 64'd0);
        check_val("zero_valid", 64'(out_valid), 64'd0);
        if (t == 3) finished = 1'b1;
        continue;
      end

      if (abort_after > 0 && accepted == abort_after) begin
        rst = 1'b1;
        #1;
        check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        finished  = 1'b1;
        break;
      end

      if (prev_valid && !prev_ready) begin
        check_val("stall_valid", 64'(out_valid), 64'd1);
        check_val("stall_data", 64'(out_data), 64'(prev_data));
        check_val("stall_last", 64'(out_last), 64'(prev_last));
      end

      if (busy) begin
        ahead = z_addr - 32'(accepted);
        check_val("addr_ahead", 64'(ahead <= 32'd2), 64'd1);
      end

      if (out_valid && first_t < 0) begin
        first_t = t;
        check_val("first_valid_t", 64'(t), 64'd3);
      end

      if (done) begin
        check_val("done_busy", 64'(busy), 64'd0);
        check_val("done_valid", 64'(out_valid), 64'd0);
        check_val("done_all_words", 64'(q.size()), 64'd0);
        if (mode == 0) check_val("done_t", 64'(t), 64'(n + 3));
        $display("run %0dx%0d mode %0d: done at cycle %0d, %0d words", rows, cols, mode, t, accepted);
        finished = 1'b1;
      end else begin
        check_val("busy_high", 64'(busy), 64'd1);
      end

      if (out_valid && ready) begin
        if (q.size() == 0) begin
          check_val("extra_word", 64'(out_data), 64'd0);
          check_val("extra_word_seen", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check_val("word_data", 64'(out_data), 64'(e.d));
          check_val("word_last", 64'(out_last), 64'(e.last));
`ifdef MATRIX_READER_ROW_LAST_EN
          check_val("word_row_last", 64'(out_row_last), 64'(e.rl));
`endif
          $display("xfer %0d: data %08h last %0b", accepted, out_data, out_last);
        end
        accepted++;
      end

      prev_valid = out_valid;
      prev_ready = ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end

    if (!finished) check_val("timeout", 64'd0, 64'd1);

    out_ready = 1'b1;
    if (inject != 0) begin
      repeat (2) begin
        @(negedge clk);
        check_val("inject_busy", 64'(busy), 64'd0);
        check_val("inject_valid", 64'(out_valid), 64'd0);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    z_rows    = '0;
    z_cols    = '0;
    for (int i = 0; i < 64; i++) z_mem[i] = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run(2, 3, 0, 1, 0, 0);
    run(2, 3, 1, 1, 0, 0);
    run(0, 4, 0, 0, 0, 0);
    run(1, 1, 0, 2, 0, 1);
    run(3, 2, 0, 0, 2, 0);
    run(3, 2, 0, 1, 0, 0);
    run(3, 2, 2, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      run(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 2, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/matrix_result_reader.md
# matrix_result_reader

Reads a completed result matrix Z out of the Z RAM written by the matrix multiplier and presents it, row-major, as a valid/ready stream toward the host/DMA side. It issues Z RAM read addresses itself, absorbs the one-cycle RAM read latency, and handles downstream backpressure through a 2-entry show-ahead buffer. It is started once the multiplier drops `busy`, and it owns the Z RAM read port while its own `busy` is high.

## Interface
- `ADDR_WIDTH`, 32, width of address and dimension ports
- `DATA_WIDTH`, 32, width of Z RAM words and stream data

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  begin readout; sampled only in IDLE
- `z_rows`  in  ADDR_WIDTH  rows of Z (multiplier's x_rows); sampled at accepted start
- `z_cols`  in  ADDR_WIDTH  columns of Z (multiplier's y_cols); sampled at accepted start
- `z_data`  in  DATA_WIDTH  Z RAM read data, valid one cycle after `z_addr`
- `z_addr`  out  ADDR_WIDTH  Z RAM read address (registered)
- `out_data`  out  DATA_WIDTH  stream word
- `out_valid`  out  1  stream word valid
- `out_ready`  in  1  downstream accepts; transfer = `out_valid & out_ready`
- `out_last`  out  1  high with the final element of Z
- `busy`  out  1  high from the cycle after accepted start until done
- `done`  out  1  one-cycle pulse when readout completes

## Operation
- States: IDLE, READ, DRAIN.
- IDLE: `start` high → latch `z_rows`/`z_cols`; clear `z_addr`, row and column counters. If either dimension is 0 → pulse `done` next cycle and stay in IDLE; no stream words. Otherwise → READ.
- READ: an issue occurs in any cycle where fifo_count + inflight − pop < 2 (pop = transfer this cycle). On issue: the current `z_addr` is read, inflight is set for the next cycle, `z_addr` += 1, column += 1, wrapping to 0 with row += 1 at `z_cols`−1. Issue of element (z_rows−1, z_cols−1) → DRAIN.
- Data returning from an issue is written into the FIFO at the end of the following cycle, tagged with last = (issued element was the final one).
- DRAIN: no issues. When FIFO is empty and nothing is inflight → pulse `done`, drop `busy`, go to IDLE.
- `start` outside IDLE is ignored.
- Counters are ADDR_WIDTH wide. Element count is not computed by multiplication; termination is by row/column compare. `z_addr` never exceeds z_rows·z_cols − 1 by issue.
- `out_data`/`out_last` stay stable while `out_valid & !out_ready`.
- Reset at any time: state IDLE, FIFO emptied, inflight cleared; in-progress readout is lost.

## Timing
- Reset values: `z_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0.
- Start accepted at edge E0 → READ, first issue in cycle after E0 → first `out_valid` 3 cycles after the start cycle.
- With `out_ready` held high: one word per cycle, no bubbles. N elements → `done` N+3 cycles after the start cycle.
- `out_ready` low: at most 2 issues are outstanding, and issue stalls. Throughput resumes the cycle after `out_ready` rises.
- `done` is asserted in the cycle after the last transfer, coincident with `busy` falling.

## Configuration
- `MATRIX_READER_ROW_LAST_EN` defined: adds output `out_row_last` (1 bit). It is high with the final element of each row and carried through the FIFO like `out_last`. Reset value 0.
- Undefined: port absent. Row tag is not stored; FIFO entry width = DATA_WIDTH+1.

## Structure
- Shared package `matrix_pkg`: state enum (IDLE, READ, DRAIN), `RESULT_FIFO_DEPTH` = 2.
- One sub-module `result_fifo`: 2-entry show-ahead FIFO with async reset, push/pop/count, and data+tag width parameter. Credit logic, counters, and FSM stay in `matrix_result_reader`.

## Test plan
- 2×3 Z = {1..6}, `out_ready`=1 → words 1,2,3,4,5,6 on consecutive cycles, first valid 3 cycles after start. `out_last` only on 6; `done` 9 cycles after start.
- Same Z, `out_ready` toggling 1,0,0,1,… → same sequence with no loss or duplicates. `z_addr` never more than 2 ahead of accepted count; data stable while stalled.
- `z_rows`=0, `z_cols`=4 → `done` the cycle after start, `out_valid` never high, `busy` never high.
- 1×1 Z = {0xDEADBEEF} → single word with `out_last`=1, then `done`. Second `start` asserted mid-run is ignored.
- 3×2 readout, `rst` pulsed after 2 transfers → all outputs return to reset values immediately. A fresh start reads again from address 0.
- With `MATRIX_READER_ROW_LAST_EN`, 3×2 → `out_row_last` high on elements 2, 4, 6.
